// File: rtl/read_empty_block_if.sv
// -----------------------------------------------------------------------------
// read_empty_block_if
// Bundles the read-side FIFO signals of read_empty_block.
//   write_pointer_i     : gray write pointer from the write domain (async)
//   read_data_i         : memory read data, combinational in read_addr_o
//   read_ready_i        : consumer accepts read_data_o this cycle
//   read_addr_o         : memory read address
//   read_pointer_o      : registered gray read pointer to the write domain
//   read_data_o         : FIFO head word
//   read_valid_o        : read_data_o holds a valid word
//   read_empty_o        : memory holds no unpopped word
//   read_almost_empty_o : memory holds at most one unpopped word
//   read_level_o        : unpopped words in memory (output register excluded)
// modport slave  : the controller side (read_empty_block)
// modport master : the memory / write-pointer / consumer side
// -----------------------------------------------------------------------------
interface read_empty_block_if #(
    parameter int addr_size  = 3,
    parameter int data_width = 8
);
    logic [addr_size:0]    write_pointer_i;
    logic [data_width-1:0] read_data_i;
    logic                  read_ready_i;
    logic [addr_size-1:0]  read_addr_o;
    logic [addr_size:0]    read_pointer_o;
    logic [data_width-1:0] read_data_o;
    logic                  read_valid_o;
    logic                  read_empty_o;
    logic                  read_almost_empty_o;
    logic [addr_size:0]    read_level_o;

    modport slave (
        input  write_pointer_i,
        input  read_data_i,
        input  read_ready_i,
        output read_addr_o,
        output read_pointer_o,
        output read_data_o,
        output read_valid_o,
        output read_empty_o,
        output read_almost_empty_o,
        output read_level_o
    );

    modport master (
        output write_pointer_i,
        output read_data_i,
        output read_ready_i,
        input  read_addr_o,
        input  read_pointer_o,
        input  read_data_o,
        input  read_valid_o,
        input  read_empty_o,
        input  read_almost_empty_o,
        input  read_level_o
    );
endinterface

// File: rtl/read_empty_block.sv
// -----------------------------------------------------------------------------
// read_empty_block
// Read-side pointer and flag controller of a dual-clock FIFO. Synchronises the
// gray write pointer into the read clock domain, keeps the binary and gray
// read pointers, produces empty / almost-empty / level, and holds a
// first-word-fall-through output register with a valid/ready handshake.
// Ports:
//   read_clock_i : read-domain clock
//   read_reset_i : synchronous, active-high reset
//   rd           : read_empty_block_if.slave bundle (see interface header)
// -----------------------------------------------------------------------------
module read_empty_block #(
    parameter int addr_size   = 3,
    parameter int data_width  = 8,
    parameter int sync_stages = 2
) (
    input  logic              read_clock_i,
    input  logic              read_reset_i,
    read_empty_block_if.slave rd
);
    localparam int PW = addr_size + 1;

    // Synchroniser chain: plain flops only, stage 0 samples the async pointer.
    logic [PW-1:0] sync_reg [sync_stages];
    logic [PW-1:0] wq;
    logic [PW-1:0] wq_binary;

    // Pointer / output state
    logic [PW-1:0]         read_binary_reg;
    logic [PW-1:0]         read_pointer_reg;
    logic [data_width-1:0] read_data_reg;
    logic                  read_valid_reg;
    logic                  read_empty_reg;
    logic                  read_almost_empty_reg;
    logic [PW-1:0]         read_level_reg;

    // Next-state terms
    logic          pop;
    logic [PW-1:0] read_binary_next;
    logic [PW-1:0] gray_next;
    logic [PW-1:0] binary_plus_one;
    logic [PW-1:0] gray_plus_one;

    always_ff @(posedge read_clock_i) begin
        if (read_reset_i) begin
            for (int i = 0; i < sync_stages; i++) begin
                sync_reg[i] <= '0;
            end
        end else begin
            sync_reg[0] <= rd.write_pointer_i;
            for (int i = 1; i < sync_stages; i++) begin
                sync_reg[i] <= sync_reg[i-1];
            end
        end
    end

    assign wq = sync_reg[sync_stages-1];

    // Gray to binary: each binary bit is the XOR of all gray bits at or above it.
    genvar gi;
    generate
        for (gi = 0; gi < PW; gi++) begin : g_gray2bin
            assign wq_binary[gi] = ^wq[PW-1:gi];
        end
    endgenerate

    // Pop the memory whenever a word is available and the output register is
    // free or being drained this cycle; never pop while empty.
    assign pop              = ~read_empty_reg & (~read_valid_reg | rd.read_ready_i);
    assign read_binary_next = read_binary_reg + PW'(pop);
    assign gray_next        = (read_binary_next >> 1) ^ read_binary_next;
    assign binary_plus_one  = read_binary_next + PW'(1);
    assign gray_plus_one    = (binary_plus_one >> 1) ^ binary_plus_one;

    always_ff @(posedge read_clock_i) begin
        if (read_reset_i) begin
            read_binary_reg       <= '0;
            read_pointer_reg      <= '0;
            read_data_reg         <= '0;
            read_valid_reg        <= 1'b0;
            read_empty_reg        <= 1'b1;
            read_almost_empty_reg <= 1'b1;
            read_level_reg        <= '0;
        end else begin
            read_binary_reg  <= read_binary_next;
            read_pointer_reg <= gray_next;

            if (pop) begin
                read_data_reg  <= rd.read_data_i;
                read_valid_reg <= 1'b1;
            end else if (read_valid_reg & rd.read_ready_i) begin
                read_valid_reg <= 1'b0;
            end

            // Flags compare against the synchronised (older) write pointer,
            // so they can only err towards empty.
            read_empty_reg        <= (gray_next == wq);
            read_almost_empty_reg <= (gray_next == wq) | (gray_plus_one == wq);
            read_level_reg        <= wq_binary - read_binary_next;
        end
    end

    assign rd.read_addr_o         = read_binary_reg[addr_size-1:0];
    assign rd.read_pointer_o      = read_pointer_reg;
    assign rd.read_data_o         = read_data_reg;
    assign rd.read_valid_o        = read_valid_reg;
    assign rd.read_empty_o        = read_empty_reg;
    assign rd.read_almost_empty_o = read_almost_empty_reg;
    assign rd.read_level_o        = read_level_reg;

endmodule
